// File: rtl/fsic_io_tx_serializer.sv
// fsic_io_tx_serializer
// 4:1 transmit serializer for the FSIC IO SerDes, clocked by the fast IO clock.
// Each core-clock period (four ioclk cycles) one nibble per lane is loaded and
// shifted out LSB first. An OFF/TRAIN/ACTIVE link FSM decides whether a frame
// carries zeros, the training pattern, or user data (idle pattern on underrun).
// The free-running 2-bit phase counter tracks the /4 core-clock divider, so
// phase[1] matches the divided clock when both leave reset together.

module fsic_io_tx_serializer #(
    parameter int         NLANES       = 12,
    parameter logic [3:0] TRAIN_PAT    = 4'b1010,
    parameter logic [3:0] IDLE_PAT     = 4'b0000,
    parameter int         TRAIN_FRAMES = 8
) (
    input  logic                  ioclk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic [4*NLANES-1:0]   txdata,
    input  logic                  txdata_valid,
    output logic                  txdata_ready,
    output logic [NLANES-1:0]     serial_out,
    output logic                  frame_sync,
    output logic [1:0]            phase,
    output logic [1:0]            state,
    output logic                  underrun,
    input  logic                  underrun_clr
);

    // Training counter is wide enough to hold TRAIN_FRAMES itself; it saturates there.
    localparam int               CNT_W  = $clog2(TRAIN_FRAMES + 1);
    localparam logic [CNT_W-1:0] TF_CNT = CNT_W'(TRAIN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_train_cnt;
    logic [CNT_W-1:0] w_train_cnt_next;
    logic [1:0]       r_phase;
    logic             r_underrun;
    logic             w_boundary;
    logic             w_underrun_set;

    // A frame boundary is the edge that takes phase from 3 back to 0.
    assign w_boundary = (r_phase == 2'd3);

    // Free-running phase counter, in lockstep with the core-clock divider.
    always_ff @(posedge ioclk or posedge reset) begin
        if (reset) begin
            r_phase <= 2'd0;
        end else begin
            r_phase <= r_phase + 2'd1;
        end
    end

    // Next-state decode; only consumed at boundaries, so a frame always completes.
    always_comb begin
        w_next_state     = r_state;
        w_train_cnt_next = r_train_cnt;
        if (!tx_en) begin
            // Disable overrides everything and restarts training next time.
            w_next_state     = ST_OFF;
            w_train_cnt_next = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_next_state     = ST_TRAIN;
                    w_train_cnt_next = CNT_ONE;
                end
                ST_TRAIN: begin
                    if (r_train_cnt < TF_CNT) begin
                        w_next_state     = ST_TRAIN;
                        w_train_cnt_next = r_train_cnt + CNT_ONE;
                    end else begin
                        w_next_state     = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    w_next_state     = ST_ACTIVE;
                end
                default: begin
                    w_next_state     = ST_OFF;
                    w_train_cnt_next = '0;
                end
            endcase
        end
    end

    // Link FSM and training counter advance only at frame boundaries.
    always_ff @(posedge ioclk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_OFF;
            r_train_cnt <= '0;
        end else if (w_boundary) begin
            r_state     <= w_next_state;
            r_train_cnt <= w_train_cnt_next;
        end
    end

    // An ACTIVE frame with no word available is an underrun.
    assign w_underrun_set = w_boundary && (w_next_state == ST_ACTIVE) && !txdata_valid;

    // Sticky underrun flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge ioclk or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    // Per-lane nibble selection and shift register.
    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            logic [3:0] w_nib;
            logic [2:0] r_shift;
            logic       r_bit;

            // Nibble loaded at the boundary, chosen by the state being entered.
            always_comb begin
                w_nib = 4'b0000;
                case (w_next_state)
                    ST_TRAIN:  w_nib = TRAIN_PAT;
                    ST_ACTIVE: w_nib = txdata_valid ? txdata[4*gi +: 4] : IDLE_PAT;
                    default:   w_nib = 4'b0000;
                endcase
            end

            // Bit 0 goes straight to the pin at the boundary; bits 1..3 follow.
            always_ff @(posedge ioclk or posedge reset) begin
                if (reset) begin
                    r_shift <= 3'b000;
                    r_bit   <= 1'b0;
                end else if (w_boundary) begin
                    r_bit   <= w_nib[0];
                    r_shift <= w_nib[3:1];
                end else begin
                    r_bit   <= r_shift[0];
                    r_shift <= {1'b0, r_shift[2:1]};
                end
            end

            assign serial_out[gi] = r_bit;
        end
    endgenerate

    // Load strobe is combinational so a word is taken on the boundary edge itself.
    assign txdata_ready = w_boundary && (w_next_state == ST_ACTIVE);
    assign frame_sync   = (r_phase == 2'd0) && (r_state != ST_OFF);
    assign phase        = r_phase;
    assign state        = r_state;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_fsic_io_tx_serializer.sv
// Scoreboard bench for fsic_io_tx_serializer: the driver pushes the expected
// frame at every boundary; a monitor pops and compares bit-by-bit on negedges.
module tb_fsic_io_tx_serializer;

    localparam int         NL   = 12;
    localparam int         TF   = 8;
    localparam int         W    = 4 * NL;
    localparam logic [3:0] TPAT = 4'b1010;
    localparam logic [3:0] IPAT = 4'b0000;

    logic          ioclk = 1'b0;
    logic          reset = 1'b1;
    logic          tx_en = 1'b0;
    logic [W-1:0]  txdata = '0;
    logic          txdata_valid = 1'b0;
    logic          underrun_clr = 1'b0;
    logic          txdata_ready;
    logic [NL-1:0] serial_out;
    logic          frame_sync;
    logic [1:0]    phase;
    logic [1:0]    state;
    logic          underrun;

    fsic_io_tx_serializer #(
        .NLANES(NL), .TRAIN_PAT(TPAT), .IDLE_PAT(IPAT), .TRAIN_FRAMES(TF)
    ) dut (
        .ioclk(ioclk), .reset(reset), .tx_en(tx_en), .txdata(txdata),
        .txdata_valid(txdata_valid), .txdata_ready(txdata_ready),
        .serial_out(serial_out), .frame_sync(frame_sync), .phase(phase),
        .state(state), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    always #5 ioclk = ~ioclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] bits;
        logic [1:0]   mode;
    } exp_t;

    exp_t sb_q[$];

    // Link mode from the number of consecutive enabled boundaries since OFF.
    function automatic logic [1:0] mode_of(input int run);
        if (run == 0)       return 2'd0;
        else if (run <= TF) return 2'd1;
        else                return 2'd2;
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [1:0] m, input bit v, input logic [W-1:0] d);
        case (m)
            2'd1:    return {NL{TPAT}};
            2'd2:    return v ? d : {NL{IPAT}};
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Reference bookkeeping: cycle count, enabled-run length, underrun flag.
    int tb_cyc = 0;
    int m_run  = 0;
    bit m_uf   = 1'b0;

    always @(posedge ioclk or posedge reset) begin
        if (reset) begin
            tb_cyc <= 0;
            m_run  <= 0;
            m_uf   <= 1'b0;
        end else begin
            tb_cyc <= tb_cyc + 1;
            if (tb_cyc % 4 == 3)
                m_run <= tx_en ? m_run + 1 : 0;
            if ((tb_cyc % 4 == 3) && tx_en && (mode_of(m_run + 1) == 2'd2) && !txdata_valid)
                m_uf <= 1'b1;
            else if (underrun_clr)
                m_uf <= 1'b0;
        end
    end

    // Monitor: compares every output on each negedge against the popped frame.
    bit   mon_en   = 1'b0;
    bit   have_cur = 1'b0;
    exp_t cur;

    initial begin
        int            p;
        logic [NL-1:0] expv;
        forever begin
            @(negedge ioclk);
            if (!mon_en) begin
                have_cur = 1'b0;
            end else begin
                p = tb_cyc % 4;
                check("phase", 64'(phase), 64'(p));
                if (p == 0) begin
                    if (sb_q.size() > 0) begin
                        cur      = sb_q.pop_front();
                        have_cur = 1'b1;
                    end else begin
                        check("scoreboard_depth", 64'(sb_q.size()), 64'd1);
                    end
                end
                for (int i = 0; i < NL; i++)
                    expv[i] = have_cur ? cur.bits[4*i + p] : 1'b0;
                check("serial_out", 64'(serial_out), 64'(expv));
                check("state", 64'(state), have_cur ? 64'(cur.mode) : 64'd0);
                check("frame_sync", 64'(frame_sync),
                      64'(have_cur && (p == 0) && (cur.mode != 2'd0)));
                check("underrun", 64'(underrun), 64'(m_uf));
                if (p != 3)
                    check("ready_off_boundary", 64'(txdata_ready), 64'd0);
            end
        end
    end

    // Driver helpers.
    bit clr_auto = 1'b0;
    int obs_cnt  = 0;
    int exp_cnt  = 0;

    task automatic tick();
        @(negedge ioclk);
        if (clr_auto) begin
            underrun_clr = underrun;
            if (underrun) obs_cnt++;
        end else begin
            underrun_clr = 1'b0;
        end
    endtask

    // Drive one frame: optional tx_en change at phase 1, inputs at phase 3.
    task automatic frame(input bit en, input bit vld, input logic [W-1:0] d,
                         input bit clr_now, input int early);
        int         guard;
        logic [1:0] nm;
        exp_t       e;
        guard = 0;
        do begin
            tick();
            guard++;
            if ((tb_cyc % 4 == 1) && (early >= 0)) tx_en = early[0];
        end while ((tb_cyc % 4 != 3) && (guard < 8));
        check("boundary_align", 64'(tb_cyc % 4), 64'd3);
        tx_en        = en;
        txdata_valid = vld;
        txdata       = d;
        if (clr_now) underrun_clr = 1'b1;
        nm     = mode_of(en ? m_run + 1 : 0);
        e.bits = exp_word(nm, vld, d);
        e.mode = nm;
        sb_q.push_back(e);
        if ((nm == 2'd2) && !vld) exp_cnt++;
        #1;
        check("ready_at_boundary", 64'(txdata_ready), 64'(nm == 2'd2));
        $display("frame t=%0t en=%0d vld=%0d mode=%0d data=%h ready=%0d", $time, en, vld, nm, d, txdata_ready);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        bit           v;
        // Reset state, with tx_en already high so bring-up starts at release.
        reset = 1'b1;
        tx_en = 1'b1;
        repeat (2) @(negedge ioclk);
        check("rst_serial", 64'(serial_out), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_phase", 64'(phase), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_frame_sync", 64'(frame_sync), 64'd0);
        check("rst_ready", 64'(txdata_ready), 64'd0);
        reset = 1'b0;
        #1 mon_en = 1'b1;

        // Bring-up: 8 training frames, then ACTIVE with random data.
        for (int k = 0; k < 12; k++) frame(1'b1, 1'b1, rand_word(), 1'b0, -1);

        // Serialization pattern on lane 0 and lane 11.
        for (int k = 0; k < 4; k++) begin
            d = rand_word();
            d[3:0]   = 4'hD;
            d[47:44] = 4'h6;
            frame(1'b1, 1'b1, d, 1'b0, -1);
        end

        // Underrun: sticky, then clear colliding with a new underrun, then clear.
        frame(1'b1, 1'b0, rand_word(), 1'b0, -1);
        frame(1'b1, 1'b1, rand_word(), 1'b0, -1);
        frame(1'b1, 1'b1, rand_word(), 1'b0, -1);
        frame(1'b1, 1'b0, rand_word(), 1'b1, -1);
        frame(1'b1, 1'b1, rand_word(), 1'b0, -1);
        frame(1'b1, 1'b1, rand_word(), 1'b1, -1);
        frame(1'b1, 1'b1, rand_word(), 1'b0, -1);

        // Stall tolerance: random valid gaps, underruns counted via clear loop.
        obs_cnt  = 0;
        exp_cnt  = 0;
        clr_auto = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            v = (($urandom() % 4) != 0);
            frame(1'b1, v, rand_word(), 1'b0, -1);
        end
        frame(1'b1, 1'b1, rand_word(), 1'b0, -1);
        frame(1'b1, 1'b1, rand_word(), 1'b0, -1);
        clr_auto = 1'b0;
        check("underrun_count", 64'(obs_cnt), 64'(exp_cnt));
        $display("stall phase: underruns observed=%0d expected=%0d", obs_cnt, exp_cnt);

        // Reset mid-frame with an all-ones ACTIVE frame in flight and underrun set.
        frame(1'b1, 1'b0, rand_word(), 1'b0, -1);
        frame(1'b1, 1'b1, '1, 1'b0, -1);
        @(posedge ioclk);
        @(posedge ioclk);
        #2;
        mon_en = 1'b0;
        check("pre_rst_serial", 64'(serial_out), 64'({NL{1'b1}}));
        check("pre_rst_underrun", 64'(underrun), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_serial", 64'(serial_out), 64'd0);
        check("midrst_state", 64'(state), 64'd0);
        check("midrst_underrun", 64'(underrun), 64'd0);
        check("midrst_phase", 64'(phase), 64'd0);
        check("midrst_frame_sync", 64'(frame_sync), 64'd0);
        check("midrst_ready", 64'(txdata_ready), 64'd0);
        @(negedge ioclk);
        @(negedge ioclk);
        reset = 1'b0;
        sb_q.delete();
        #1 mon_en = 1'b1;

        // Bring-up again, then disable at phase 1 of an ACTIVE frame.
        for (int k = 0; k < 11; k++) frame(1'b1, 1'b1, rand_word(), 1'b0, -1);
        frame(1'b0, 1'b1, rand_word(), 1'b0, 0);
        for (int k = 0; k < 3; k++) frame(1'b0, 1'b1, rand_word(), 1'b0, -1);
        // Short tx_en pulse away from the boundary must be ignored.
        frame(1'b0, 1'b1, rand_word(), 1'b0, 1);
        frame(1'b0, 1'b1, rand_word(), 1'b0, -1);
        repeat (4) tick();
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsic_io_tx_serializer.md
# fsic_io_tx_serializer

Transmit-side 4:1 serializer for the FSIC IO SerDes, running on the fast IO clock that feeds the /4 core-clock divider. It accepts one parallel word per core-clock period (one 4-bit nibble per lane) and shifts each nibble LSB-first onto its lane pin over four IO-clock cycles. Link bring-up is handled by an OFF/TRAIN/ACTIVE state machine that emits a training pattern before user data. An internal 2-bit phase counter runs in lockstep with the divider counter, so `phase[1]` equals the divided core clock when both leave reset together.

## Interface

Parameters:
- `NLANES`, 12: number of serial lanes.
- `TRAIN_PAT`, 4'b1010: nibble sent on every lane during TRAIN.
- `IDLE_PAT`, 4'b0000: nibble sent on every lane on ACTIVE underrun.
- `TRAIN_FRAMES`, 8: number of training frames, ≥1.

Ports:
- `ioclk` in 1: IO clock. This is the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `tx_en` in 1: link enable.
- `txdata` in 4*NLANES: parallel word. Lane i uses `txdata[4*i+3:4*i]`.
- `txdata_valid` in 1: `txdata` holds a word.
- `txdata_ready` out 1: combinational load strobe.
- `serial_out` out NLANES: registered serial bit per lane.
- `frame_sync` out 1: high while `serial_out` carries bit 0 of a frame.
- `phase` out 2: phase counter.
- `state` out 2: 0 = OFF, 1 = TRAIN, 2 = ACTIVE.
- `underrun` out 1: sticky underrun flag.
- `underrun_clr` in 1: clears `underrun`.

## Operation

- **Phase counter and boundaries.** `phase` increments by 1 every `ioclk`, wrapping 3→0. A frame boundary is the rising edge at which `phase`==3.
- **Shift register.** At every boundary the shift register loads one nibble per lane. On each of the next four edges it shifts one bit, LSB first, into `serial_out`.
- **State timing.** `next_state` is evaluated at each boundary only. State never changes on any other edge, and a frame in flight always completes.
- **Nibble source at a boundary:**
  - `next_state`=OFF: 0 on all lanes.
  - `next_state`=TRAIN: `TRAIN_PAT` on all lanes.
  - `next_state`=ACTIVE: `txdata` if `txdata_valid`, else `IDLE_PAT` on all lanes, and `underrun` is set.
- **Transitions (evaluated at boundaries):**
  - OFF→TRAIN when `tx_en`=1. `train_cnt` is set to 1.
  - TRAIN→TRAIN while `train_cnt`<`TRAIN_FRAMES`. `train_cnt` increments.
  - TRAIN→ACTIVE when `train_cnt`==`TRAIN_FRAMES`.
  - ACTIVE→ACTIVE otherwise.
  - Any state→OFF when `tx_en`=0. This has priority. `train_cnt` clears.
- **Training length.** Exactly `TRAIN_FRAMES` training frames are sent.
- **Counter width.** `train_cnt` is $clog2(TRAIN_FRAMES+1) bits wide and saturates, never wrapping.
- **Handshake.** `txdata_ready` = (`phase`==3) && (`next_state`==ACTIVE).
  - A word transfers when `txdata_valid`&&`txdata_ready`.
  - `txdata_ready` depends combinationally on `tx_en`.
  - The upstream side holds `txdata`/`txdata_valid` stable across the phase-3 cycle.
- **Underrun flag.** `underrun` is sticky. `underrun_clr` clears it on the next edge. If set and clear happen on the same edge, set wins.
- **Frame sync.** `frame_sync` = (`phase`==0) && (`state`!=OFF).

## Timing

- **Reset values.** `phase`=0, `state`=OFF, `train_cnt`=0, shift register=0, `serial_out`=0, `underrun`=0, `frame_sync`=0, `txdata_ready`=0.
- **Latency.** A word accepted at boundary edge E drives bit0 after E (phase 0), then bit1, bit2 and bit3 after E+1, E+2 and E+3.
- **Throughput.** One word every 4 `ioclk` cycles with no bubbles.
- **First boundary after reset.** This is the 4th rising edge after reset deassertion (`phase` 0→1→2→3).
- **Reset mid-frame.** All registers return to their reset values immediately. The partial frame is discarded and no word is accepted.
- **`tx_en` drop mid-frame.** The current frame completes. The next boundary loads zeros and goes to OFF.
- **`tx_en` high for one cycle, not at a boundary.** Ignored.

## Test plan

- **Reset.** Assert `reset` mid-frame with ACTIVE data in flight → the same cycle shows `serial_out`=0, `state`=0, `underrun`=0. After release, `phase` counts 0,1,2,3 on consecutive edges.
- **Bring-up.** `tx_en`=1 from reset, `TRAIN_FRAMES`=8 → every lane emits 0,1,0,1 for exactly 8 frames (32 cycles). `state`=2 from the 9th frame. `txdata_ready` pulses first on the boundary that starts that frame.
- **Serialization.** In ACTIVE, drive lane0 nibble 4'hD and lane11 nibble 4'h6, valid at every boundary → lane0 = 1,0,1,1 and lane11 = 0,1,1,0. `frame_sync` is high on the first bit only.
- **Underrun.** In ACTIVE, `txdata_valid`=0 at one boundary → that frame is all zeros and `underrun`=1. It stays 1 until `underrun_clr`. With `underrun_clr` and a new underrun on the same edge, `underrun` stays 1.
- **Disable.** Deassert `tx_en` at phase 1 of an ACTIVE frame → the frame finishes. `state`=0 after the next boundary, outputs are 0, and `txdata_ready` never asserts again.
- **Stall tolerance.** Random `txdata_valid` over 1000 frames → every accepted word appears on the lanes in order. The number of `underrun` occurrences equals the number of invalid boundaries (count them with a `underrun_clr` loop).
